// File: rtl/ff_primitive_bank.sv
// rtl/ff_primitive_bank.sv - bank of DFF, enabled DFF and enabled set/reset flops
// All outputs are driven straight from flops; clrn clears every section asynchronously.
module ff_primitive_bank #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             ena,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] dff_q,
    output logic [WIDTH-1:0] dffe_q,
    output logic [WIDTH-1:0] srffe_q
);

    logic [WIDTH-1:0] dff_state_q,   dff_state_d;
    logic [WIDTH-1:0] dffe_state_q,  dffe_state_d;
    logic [WIDTH-1:0] srffe_state_q, srffe_state_d;

    always_comb begin
        dff_state_d   = d;
        dffe_state_d  = dffe_state_q;
        srffe_state_d = srffe_state_q;
        if (ena) begin
            dffe_state_d  = d;
            // Per-bit set, then reset overrides so s=r=1 resolves to 0.
            srffe_state_d = (srffe_state_q | s) & ~r;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            dff_state_q   <= '0;
            dffe_state_q  <= '0;
            srffe_state_q <= '0;
        end else begin
            dff_state_q   <= dff_state_d;
            dffe_state_q  <= dffe_state_d;
            srffe_state_q <= srffe_state_d;
        end
    end

    assign dff_q   = dff_state_q;
    assign dffe_q  = dffe_state_q;
    assign srffe_q = srffe_state_q;

endmodule

// File: tb/tb_ff_primitive_bank.sv
// tb/tb_ff_primitive_bank.sv - scoreboard bench for ff_primitive_bank
module tb_ff_primitive_bank;

    logic       clk = 1'b0;
    logic       clrn;
    logic       ena;
    logic [7:0] d, s, r;
    logic [7:0] dff_q, dffe_q, srffe_q;

    typedef struct {
        string      name;
        logic [7:0] e_dff;
        logic [7:0] e_dffe;
        logic [7:0] e_sr;
    } exp_t;

    exp_t exp_q[$];
    event sample_ev;
    int   n_checks = 0;
    int   n_pass   = 0;

    ff_primitive_bank #(.WIDTH(8)) dut (
        .clk     (clk),
        .clrn    (clrn),
        .ena     (ena),
        .d       (d),
        .s       (s),
        .r       (r),
        .dff_q   (dff_q),
        .dffe_q  (dffe_q),
        .srffe_q (srffe_q)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input string sec, input logic [7:0] got, input logic [7:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s.%s: got %h want %h at %0t", name, sec, got, want, $time);
    endtask

    // Monitor: consumes expectations whenever the stimulus marks a sample point.
    initial begin
        forever begin
            @(sample_ev);
            while (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                cmp(e.name, "dff",   dff_q,   e.e_dff);
                cmp(e.name, "dffe",  dffe_q,  e.e_dffe);
                cmp(e.name, "srffe", srffe_q, e.e_sr);
            end
        end
    end

    task automatic expect_now(input string name, input logic [7:0] ed, input logic [7:0] ee, input logic [7:0] es);
        exp_t e;
        e.name = name; e.e_dff = ed; e.e_dffe = ee; e.e_sr = es;
        exp_q.push_back(e);
        -> sample_ev;
        #1;
    endtask

    task automatic step(input string name, input logic en, input logic [7:0] dv, input logic [7:0] sv,
                        input logic [7:0] rv, input logic [7:0] ed, input logic [7:0] ee, input logic [7:0] es);
        ena = en; d = dv; s = sv; r = rv;
        @(posedge clk);
        #2;
        expect_now(name, ed, ee, es);
    endtask

    initial begin
        clrn = 1'b0; ena = 1'b1; d = 8'hFF; s = 8'hFF; r = 8'h00;
        #1;
        expect_now("rst_init", 8'h00, 8'h00, 8'h00);
        @(posedge clk);
        #2;
        expect_now("rst_hold_edge", 8'h00, 8'h00, 8'h00);
        clrn = 1'b1;

        step("load_all_ff", 1'b1, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFF);

        // Asynchronous clear mid-cycle with every q at FF.
        #2 clrn = 1'b0;
        #1;
        expect_now("rst_async", 8'h00, 8'h00, 8'h00);
        @(posedge clk);
        #2;
        expect_now("rst_dominates", 8'h00, 8'h00, 8'h00);
        clrn = 1'b1;

        step("dff_zero",  1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        step("dff_ff",    1'b0, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00);
        step("dff_back0", 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

        step("dffe_hold0", 1'b0, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00);
        step("dffe_load",  1'b1, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00);
        step("dffe_holdF", 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00);

        step("sr_set",   1'b1, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF);
        step("sr_hold",  1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF);
        step("sr_reset", 1'b1, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00);

        step("sr_ena_off",   1'b0, 8'hA5, 8'hFF, 8'h00, 8'hA5, 8'h00, 8'h00);
        step("sr_priority",  1'b1, 8'h3C, 8'h0F, 8'h3C, 8'h3C, 8'h3C, 8'h03);
        step("sr_mixed",     1'b1, 8'h3C, 8'hF0, 8'h01, 8'h3C, 8'h3C, 8'hF2);

        // 5 ns clear pulse between edges while all inputs request FF.
        ena = 1'b1; d = 8'hFF; s = 8'hFF; r = 8'h00;
        #1 clrn = 1'b0;
        #1;
        expect_now("pulse_low", 8'h00, 8'h00, 8'h00);
        #3 clrn = 1'b1;
        @(posedge clk);
        #2;
        expect_now("pulse_recover", 8'hFF, 8'hFF, 8'hFF);

        #5;
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

endmodule
